// File: rtl/ethernet_st_arb_pkg.sv
// Shared types and helpers for the packet-atomic Avalon-ST arbiter.
package ethernet_st_arb_pkg;

    // Pointer width covers the largest supported source count (2..8).
    localparam int MAX_SRC   = 8;
    localparam int SRC_IDX_W = $clog2(MAX_SRC);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    function automatic logic [SRC_IDX_W-1:0] onehot2idx(input logic [MAX_SRC-1:0] oh);
        logic [SRC_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (oh[i]) idx = idx | SRC_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ethernet_st_rr_picker.sv
// Combinational rotate-priority search: first requester above rr_ptr, wrapping modulo NUM_SRC.
module ethernet_st_rr_picker
    import ethernet_st_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_IDX_W-1:0] rr_ptr,
    output logic [NUM_SRC-1:0]   gnt,
    output logic                 any
);

    always_comb begin
        int   idx;
        logic found;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_SRC;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/ethernet_st_packet_arbiter.sv
// Packet-atomic round-robin arbiter feeding the timing-adapter FIFO.
// Optional per-source EOP counters on port pkt_count when ARB_PKT_COUNT_EN is defined.
module ethernet_st_packet_arbiter
    import ethernet_st_arb_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = 40,
    parameter int FILL_W      = 5,
    parameter int FILL_THRESH = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            in_valid,
    input  logic [NUM_SRC-1:0]            in_sop,
    input  logic [NUM_SRC-1:0]            in_eop,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
    output logic [NUM_SRC-1:0]            in_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH+1:0]         out_data,
    input  logic                          out_ready,
    input  logic [FILL_W-1:0]             fill_level,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          err_orphan
`ifdef ARB_PKT_COUNT_EN
    ,
    output logic [NUM_SRC*16-1:0]         pkt_count
`endif
);

    arb_state_e           state_q;
    logic [SRC_IDX_W-1:0] rr_ptr_q;
    logic [NUM_SRC-1:0]   grant_q;
    logic                 err_q;

    logic [NUM_SRC-1:0]    pick_gnt;
    logic                  pick_any;
    logic                  fill_ok;
    logic [NUM_SRC-1:0]    orphan;
    logic                  owner_valid;
    logic                  owner_sop;
    logic                  owner_eop;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  accept_eop;

    ethernet_st_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .req    (in_valid & in_sop),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .any    (pick_any)
    );

    assign fill_ok = (fill_level <= FILL_W'(FILL_THRESH));

    // Owner beat selected by AND-OR with the one-hot grant, avoiding a variable-width index.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) owner_data = owner_data | in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign owner_valid = |(in_valid & grant_q);
    assign owner_sop   = |(in_sop & grant_q);
    assign owner_eop   = |(in_eop & grant_q);
    assign out_data    = {owner_sop, owner_eop, owner_data};

    // Reset gates the handshakes so no beat is accepted or emitted while it is held.
    assign orphan = (state_q == ST_IDLE && !reset) ? (in_valid & ~in_sop) : '0;

    always_comb begin
        in_ready  = '0;
        out_valid = 1'b0;
        if (!reset) begin
            if (state_q == ST_XFER) begin
                out_valid = owner_valid;
                in_ready  = grant_q & {NUM_SRC{out_ready}};
            end else begin
                in_ready = orphan;
            end
        end
    end

    assign accept_eop = (state_q == ST_XFER) && owner_valid && owner_eop && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= |orphan;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any && fill_ok) begin
                        grant_q <= pick_gnt;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept_eop) begin
                        rr_ptr_q <= onehot2idx(MAX_SRC'(grant_q));
                        grant_q  <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant      = grant_q;
    assign err_orphan = err_q;

`ifdef ARB_PKT_COUNT_EN
    logic [NUM_SRC-1:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (accept_eop) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q[i]) cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_ethernet_st_packet_arbiter.sv
// Scoreboard bench for ethernet_st_packet_arbiter: queued source drivers, expected-beat and expected-grant queues.
module tb_ethernet_st_packet_arbiter;

    localparam int NS = 4;
    localparam int DW = 40;
    localparam int FW = 5;

    typedef logic [DW+1:0] beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NS-1:0]    in_valid, in_sop, in_eop, in_ready;
    logic [NS*DW-1:0] in_data;
    logic             out_valid, out_ready, err_orphan;
    logic [DW+1:0]    out_data;
    logic [FW-1:0]    fill_level;
    logic [NS-1:0]    grant;
`ifdef ARB_PKT_COUNT_EN
    logic [NS*16-1:0] pkt_count;
`endif

    always #5 clk = ~clk;

    ethernet_st_packet_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .FILL_W(FW), .FILL_THRESH(12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .grant      (grant),
        .err_orphan (err_orphan)
`ifdef ARB_PKT_COUNT_EN
        ,
        .pkt_count  (pkt_count)
`endif
    );

    beat_t src_q [NS][$];
    beat_t exp_q [$];
    int    exp_gnt [$];
    int    checks = 0;
    int    errors = 0;
    logic [NS-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NS-1:0] onehot(input int i);
        logic [NS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Queue one packet on source s and record its beats and grant as expected output.
    task automatic push_pkt(input int s, input int pkt, input int nbeats);
        beat_t x;
        for (int b = 0; b < nbeats; b++) begin
            x[DW+1]   = (b == 0);
            x[DW]     = (b == nbeats - 1);
            x[DW-1:0] = DW'(s * 'h10000 + pkt * 'h100 + b);
            src_q[s].push_back(x);
            exp_q.push_back(x);
        end
        exp_gnt.push_back(s);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  n;
        logic busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            tick();
            n++;
            busy = (exp_q.size() != 0) || (grant != '0);
            for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) busy = 1'b1;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=busy expected=idle after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_exp_left(input string name, input int left, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > left && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() > left) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=%0d expected=%0d beats pending", name, exp_q.size(), left);
        end
    endtask

    // Source driver: pops a beat the cycle after its handshake, then presents the next head.
    initial begin
        beat_t b;
        logic [NS-1:0] fire;
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            fire = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    in_valid[i]          = 1'b1;
                    in_sop[i]            = b[DW+1];
                    in_eop[i]            = b[DW];
                    in_data[i*DW +: DW]  = b[DW-1:0];
                end else begin
                    in_valid[i] = 1'b0;
                    in_sop[i]   = 1'b0;
                    in_eop[i]   = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted output beat and every new grant is matched against the queues.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected actual=%0h expected=none", out_data);
            end else begin
                check("beat", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
        if (grant != '0 && prev_grant == '0) begin
            if (exp_gnt.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected actual=%0b expected=none", grant);
            end else begin
                check("grant_order", 64'(grant), 64'(onehot(exp_gnt.pop_front())));
            end
        end
        prev_grant <= grant;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t held;
        reset      = 1'b1;
        out_ready  = 1'b0;
        fill_level = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_grant", 64'(grant), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_err_orphan", 64'(err_orphan), 0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;

        // Single packet from src3 leaves rr_ptr at 3.
        push_pkt(3, 0, 3);
        wait_idle("src3_pkt", 50);

        // All sources busy: rotation 0,1,2,3,0 with contiguous beats.
        push_pkt(0, 1, 3);
        push_pkt(1, 1, 3);
        push_pkt(2, 1, 3);
        push_pkt(3, 1, 3);
        push_pkt(0, 2, 3);
        wait_idle("fairness", 200);

        // Fill threshold: 13 and 16 hold, 12 grants; fill ignored once in XFER.
        push_pkt(2, 3, 2);
        fill_level = 5'd13;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 2) fill_level = 5'd16;
            @(negedge clk);
            check("thresh_hold_grant", 64'(grant), 0);
            check("thresh_hold_ready", 64'(in_ready[2]), 0);
            tick();
        end
        fill_level = 5'd12;
        @(negedge clk);
        check("thresh_pre_grant", 64'(grant), 0);
        tick();
        @(negedge clk);
        check("thresh_grant", 64'(grant), 64'(4'b0100));
        fill_level = 5'd16;
        wait_idle("thresh_pkt", 50);
        fill_level = '0;

        // One-beat packet under toggling out_ready: exactly one beat, then idle.
        out_ready = 1'b0;
        push_pkt(0, 4, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            out_ready = (k % 2 == 1);
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("one_beat_idle", 64'(grant), 0);
        check("one_beat_left", 64'(exp_q.size()), 0);

        // Orphan on src3 is drained while src1 is arbitrated in parallel.
        src_q[3].push_back({1'b0, 1'b0, DW'('hdead)});
        push_pkt(1, 5, 1);
        tick();
        @(negedge clk);
        check("orphan_ready", 64'(in_ready[3]), 1);
        check("orphan_err_pre", 64'(err_orphan), 0);
        tick();
        @(negedge clk);
        check("orphan_err_pulse", 64'(err_orphan), 1);
        tick();
        @(negedge clk);
        check("orphan_err_end", 64'(err_orphan), 0);
        wait_idle("orphan", 50);

        // Five-cycle stall mid-packet from src1.
        push_pkt(1, 6, 4);
        wait_exp_left("stall_start", 2, 50);
        out_ready = 1'b0;
        held = exp_q[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 1);
            check("stall_data", 64'(out_data), 64'(held));
            check("stall_ready", 64'(in_ready[1]), 0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle("stall_resume", 50);

        // Reset mid-packet: src1 owner after 3 of 5 beats, rr_ptr previously 2.
        push_pkt(2, 7, 1);
        wait_idle("pre_reset", 50);
        push_pkt(1, 8, 5);
        wait_exp_left("reset_point", 2, 50);
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_grant", 64'(grant), 0);
        check("midrst_out_valid", 64'(out_valid), 0);
        check("midrst_in_ready", 64'(in_ready), 0);
        check("midrst_abandoned", 64'(exp_q.size()), 2);
        for (int i = 0; i < NS; i++) src_q[i].delete();
        exp_q.delete();
        exp_gnt.delete();
        tick();
        reset = 1'b0;
        // rr_ptr back to 0: src1 first, then 3, then 0.
        push_pkt(1, 10, 1);
        push_pkt(3, 11, 1);
        push_pkt(0, 9, 1);
        wait_idle("post_reset", 50);

`ifdef ARB_PKT_COUNT_EN
        check("cnt_post_rst_src1", 64'(pkt_count[31:16]), 1);
        for (int p = 0; p < 70000; p++) push_pkt(0, p % 256, 1);
        wait_idle("count_run", 150000);
        check("cnt_src0_wrap", 64'(pkt_count[15:0]), 64'(4465));
        check("cnt_src1", 64'(pkt_count[31:16]), 1);
        check("cnt_src2", 64'(pkt_count[47:32]), 0);
        check("cnt_src3", 64'(pkt_count[63:48]), 1);
`endif

        check("exp_beats_drained", 64'(exp_q.size()), 0);
        check("exp_grants_drained", 64'(exp_gnt.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
